// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: mode and FSM state encodings shared by the mux_scan_seq slice.
package mux_scan_pkg;
    typedef enum logic [1:0] {MANUAL = 2'b00, SCAN = 2'b01, HOLD = 2'b10, ONESHOT = 2'b11} mode_e;
    typedef enum logic [1:0] {S_MANUAL, S_SCAN, S_HOLD, S_DONE} state_e;
endpackage

// File: rtl/mux_next_ch.sv
// mux_next_ch: next enabled channel above i_cur (wrapping to the lowest enabled one),
// plus wrapped / none-enabled flags and the lowest enabled index.
module mux_next_ch #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  i_cur,
    input  logic [NUM_CH-1:0] i_ch_en,
    output logic [SEL_W-1:0]  o_next,
    output logic              o_wrap,
    output logic              o_none,
    output logic [SEL_W-1:0]  o_low
);
    logic w_hit;
    always_comb begin
        o_low = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (i_ch_en[k]) o_low = SEL_W'(k);
        w_hit  = 1'b0;
        o_next = o_low;
        for (int k = 0; k < NUM_CH; k++)
            if (!w_hit && i_ch_en[k] && k > int'(i_cur)) begin
                o_next = SEL_W'(k);
                w_hit  = 1'b1;
            end
    end
    assign o_wrap = !w_hit;
    assign o_none = ~|i_ch_en;
endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N-channel TDM mux with manual select, round-robin scan,
// hold and one-shot sweep modes.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int WIDTH   = 2,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(NUM_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic [NUM_CH*WIDTH-1:0] i_data_in,
    input  logic [1:0]              i_mode,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [DWELL_W-1:0]      i_dwell,
    input  logic [NUM_CH-1:0]       i_ch_en,
    output logic [WIDTH-1:0]        o_data_out,
    output logic [SEL_W-1:0]        o_ch_out,
    output logic                    o_valid,
    output logic                    o_wrap,
    output logic                    o_done
);
    state_e             r_state, w_state;
    logic               r_one, w_one;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [SEL_W-1:0]   r_ch, w_ch;
    logic [WIDTH-1:0]   r_data, w_data;
    logic               r_valid, w_valid, r_wrap, w_wrap, r_done, w_done;
    logic               w_entry, w_step, w_run, w_wrapped, w_none;
    logic [SEL_W-1:0]   w_msel, w_next, w_low;
    logic [WIDTH-1:0]   w_d_sel, w_d_cur, w_d_next, w_d_low;
    mode_e              w_mode;

    mux_next_ch #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_next (
        .i_cur   (r_ch),
        .i_ch_en (i_ch_en),
        .o_next  (w_next),
        .o_wrap  (w_wrapped),
        .o_none  (w_none),
        .o_low   (w_low)
    );

    // Out-of-range manual selects fall back to channel 0.
    always_comb begin
        w_msel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (i_sel == SEL_W'(k)) w_msel = i_sel;
    end

    assign w_mode   = mode_e'(i_mode);
    assign w_d_sel  = i_data_in[int'(w_msel)*WIDTH +: WIDTH];
    assign w_d_cur  = i_data_in[int'(r_ch)*WIDTH +: WIDTH];
    assign w_d_next = i_data_in[int'(w_next)*WIDTH +: WIDTH];
    assign w_d_low  = i_data_in[int'(w_low)*WIDTH +: WIDTH];
    assign w_run    = (r_state == S_SCAN) && r_one;

    always_comb begin
        w_state = r_state;
        w_one   = r_one;
        w_cnt   = r_cnt;
        w_ch    = r_ch;
        w_data  = r_data;
        w_valid = r_valid;
        w_wrap  = 1'b0;
        w_done  = 1'b0;
        w_entry = 1'b0;
        w_step  = 1'b0;
        case (w_mode)
            MANUAL: begin
                w_state = S_MANUAL;
                w_ch    = w_msel;
                w_data  = w_d_sel;
                w_valid = 1'b1;
            end
            HOLD: w_state = S_HOLD;
            SCAN: begin
                w_entry = (r_state == S_MANUAL) || (r_state == S_DONE) || w_run;
                w_step  = !w_entry;
            end
            default: begin
                w_entry = (r_state != S_DONE) && !w_run;
                w_step  = w_run;
            end
        endcase
        if (w_entry || w_step) begin
            w_state = S_SCAN;
            w_one   = (w_mode == ONESHOT);
            if (w_none) begin
                w_valid = 1'b0;
                w_state = w_one ? S_DONE : S_SCAN;
                w_done  = w_one;
            end else if (w_entry) begin
                w_ch    = w_low;
                w_data  = w_d_low;
                w_cnt   = i_dwell;
                w_valid = 1'b1;
            end else if (r_cnt != '0) begin
                w_cnt   = r_cnt - 1'b1;
                w_data  = w_d_cur;
                w_valid = 1'b1;
            end else if (w_one && w_wrapped) begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_valid = 1'b1;
            end else begin
                w_ch    = w_next;
                w_data  = w_d_next;
                w_cnt   = i_dwell;
                w_valid = 1'b1;
                w_wrap  = w_wrapped;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_MANUAL;
            r_one   <= 1'b0;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_ena) begin
            r_state <= w_state;
            r_one   <= w_one;
            r_cnt   <= w_cnt;
            r_ch    <= w_ch;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_wrap  <= w_wrap;
            r_done  <= w_done;
        end
    end

    assign o_data_out = r_data;
    assign o_ch_out   = r_ch;
    assign o_valid    = r_valid;
    assign o_wrap     = r_wrap & i_ena;
    assign o_done     = r_done & i_ena;
endmodule
